// File: rtl/fp32_divider.sv
// Multi-cycle IEEE754 single-precision divider (res = op1 / op2), restoring mantissa divide, RNE, denormals flushed.
// Latency: done 31 edges after start (2 for special operands); ready ignored while busy.
module fp32_divider #(
    parameter logic [31:0] NAN_VALUE = 32'h7FFFFFFF,
    parameter int          QBITS     = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] res,
    output logic        done,
    output logic        busy
);

    localparam int CNT_W = $clog2(QBITS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(QBITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DIV,
        ST_NORM,
        ST_ROUND,
        ST_PACK,
        ST_FINISH
    } state_t;

    state_t             state;
    logic               s1, s2, sign;
    logic [7:0]         e1, e2;
    logic [22:0]        f1, f2;
    logic signed [9:0]  exp;
    logic [25:0]        rem;
    logic [23:0]        dvs;
    logic [QBITS-1:0]   q;
    logic [CNT_W-1:0]   count;
    logic [22:0]        frac;
    logic               g, st;
    logic [31:0]        result;

    logic nan1, nan2, inf1, inf2, zero1, zero2, num1;
    logic is_nan, is_inf, is_zero;
    logic               ge;
    logic [25:0]        diff;
    logic [23:0]        frac_inc;
    logic               round_up;
    logic signed [9:0]  exp_start;

    always_comb begin
        nan1  = (e1 == 8'hFF) && (f1 != 23'd0);
        nan2  = (e2 == 8'hFF) && (f2 != 23'd0);
        inf1  = (e1 == 8'hFF) && (f1 == 23'd0);
        inf2  = (e2 == 8'hFF) && (f2 == 23'd0);
        zero1 = (e1 == 8'd0);
        zero2 = (e2 == 8'd0);
        num1  = !nan1 && !inf1 && !zero1;
        // Tests are evaluated in priority order in ST_CHECK
        is_nan  = nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2);
        is_inf  = inf1 || (num1 && zero2);
        is_zero = zero1 || (num1 && inf2);
        exp_start = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;

        ge   = (rem >= {2'b00, dvs});
        diff = rem - {2'b00, dvs};

        frac_inc = {1'b0, frac} + 24'd1;
        round_up = g && (st || frac[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            res    <= 32'd0;
            done   <= 1'b0;
            busy   <= 1'b0;
            s1     <= 1'b0;
            s2     <= 1'b0;
            sign   <= 1'b0;
            e1     <= 8'd0;
            e2     <= 8'd0;
            f1     <= 23'd0;
            f2     <= 23'd0;
            exp    <= 10'sd0;
            rem    <= 26'd0;
            dvs    <= 24'd0;
            q      <= '0;
            count  <= '0;
            frac   <= 23'd0;
            g      <= 1'b0;
            st     <= 1'b0;
            result <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (ready) begin
                        {s1, e1, f1} <= op1;
                        {s2, e2, f2} <= op2;
                        busy  <= 1'b1;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    sign <= s1 ^ s2;
                    if (is_nan) begin
                        result <= NAN_VALUE;
                        state  <= ST_FINISH;
                    end else if (is_inf) begin
                        result <= {s1 ^ s2, 8'hFF, 23'd0};
                        state  <= ST_FINISH;
                    end else if (is_zero) begin
                        result <= {s1 ^ s2, 31'd0};
                        state  <= ST_FINISH;
                    end else begin
                        exp   <= exp_start;
                        rem   <= {3'b001, f1};
                        dvs   <= {1'b1, f2};
                        q     <= '0;
                        count <= '0;
                        state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    // rem stays below 2*dvs, so the shifted value always fits in 26 bits
                    rem   <= (ge ? diff : rem) << 1;
                    q     <= {q[QBITS-2:0], ge};
                    count <= count + 1'b1;
                    if (count == LAST_ITER)
                        state <= ST_NORM;
                end
                ST_NORM: begin
                    if (q[25]) begin
                        frac <= q[24:2];
                        g    <= q[1];
                        st   <= q[0] || (rem != 26'd0);
                    end else begin
                        frac <= q[23:1];
                        g    <= q[0];
                        st   <= (rem != 26'd0);
                        exp  <= exp - 10'sd1;
                    end
                    state <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (round_up) begin
                        frac <= frac_inc[22:0];
                        if (frac_inc[23])
                            exp <= exp + 10'sd1;
                    end
                    state <= ST_PACK;
                end
                ST_PACK: begin
                    if (exp >= 10'sd255)
                        result <= {sign, 8'hFF, 23'd0};
                    else if (exp <= 10'sd0)
                        result <= {sign, 31'd0};
                    else
                        result <= {sign, exp[7:0], frac};
                    state <= ST_FINISH;
                end
                ST_FINISH: begin
                    res   <= result;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_divider.sv
// Directed self-checking bench for fp32_divider: normal, rounding, specials, range limits, handshake, reset.
module tb_fp32_divider;

    logic        clk;
    logic        rst;
    logic        ready;
    logic [31:0] op1, op2;
    logic [31:0] res;
    logic        done;
    logic        busy;

    int tests = 0;
    int fails = 0;

    fp32_divider dut (
        .clk   (clk),
        .rst   (rst),
        .ready (ready),
        .op1   (op1),
        .op2   (op2),
        .res   (res),
        .done  (done),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one op, scrambles the operand inputs after the start edge, and
    // returns the result, the edge count to done (start edge = 0) and whether busy held.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat, output logic busy_ok);
        @(negedge clk);
        op1 = a; op2 = b; ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready = 1'b0; op1 = $urandom; op2 = $urandom;
        lat = 0; busy_ok = 1'b1;
        while (!done && lat < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = res;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b0; op1 = 32'd0; op2 = 32'd0;
        repeat (2) @(negedge clk);
        tests++; if (res !== 32'd0) begin fails++; $display("FAIL reset_res: got %h want 00000000", res); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_normal();
        logic [31:0] r; int lat; logic bok;
        run_op(32'h40C00000, 32'h40000000, r, lat, bok);
        tests++; if (r !== 32'h40400000) begin fails++; $display("FAIL six_div_two: got %h want 40400000", r); end
        tests++; if (lat != 31) begin fails++; $display("FAIL six_div_two_latency: got %0d want 31", lat); end
        tests++; if (bok !== 1'b1) begin fails++; $display("FAIL busy_during_op: got %b want 1", bok); end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_one_cycle: got %b want 0", done); end
        tests++; if (res !== 32'h40400000) begin fails++; $display("FAIL res_held: got %h want 40400000", res); end
    endtask

    task automatic test_round();
        logic [31:0] r; int lat; logic bok;
        run_op(32'h3F800000, 32'h40400000, r, lat, bok);
        tests++; if (r !== 32'h3EAAAAAB) begin fails++; $display("FAIL one_third: got %h want 3EAAAAAB", r); end
        tests++; if (lat != 31) begin fails++; $display("FAIL one_third_latency: got %0d want 31", lat); end
        run_op(32'hBF800000, 32'h40000000, r, lat, bok);
        tests++; if (r !== 32'hBF000000) begin fails++; $display("FAIL neg_half: got %h want BF000000", r); end
    endtask

    task automatic test_specials();
        logic [31:0] a [5] = '{32'hBF800000, 32'h00000000, 32'h7F800000, 32'h00000000, 32'h00000001};
        logic [31:0] b [5] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'hC0000000, 32'h3F800000};
        logic [31:0] e [5] = '{32'hFF800000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00000000};
        logic [31:0] r; int lat; logic bok;
        for (int i = 0; i < 5; i++) begin
            run_op(a[i], b[i], r, lat, bok);
            tests++; if (r !== e[i]) begin fails++; $display("FAIL special_%0d: got %h want %h", i, r, e[i]); end
            tests++; if (lat != 2) begin fails++; $display("FAIL special_%0d_latency: got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_range();
        logic [31:0] a [3] = '{32'h7F000000, 32'h00800000, 32'h3F800000};
        logic [31:0] b [3] = '{32'h3E800000, 32'h40000000, 32'h7F7FFFFF};
        logic [31:0] e [3] = '{32'h7F800000, 32'h00000000, 32'h00000000};
        logic [31:0] r; int lat; logic bok;
        for (int i = 0; i < 3; i++) begin
            run_op(a[i], b[i], r, lat, bok);
            tests++; if (r !== e[i]) begin fails++; $display("FAIL range_%0d: got %h want %h", i, r, e[i]); end
        end
    endtask

    task automatic test_ignore_ready();
        int ndone = 0; logic [31:0] r = 32'd0;
        @(negedge clk);
        op1 = 32'h40C00000; op2 = 32'h40000000; ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready = 1'b0;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 5) begin ready = 1'b1; op1 = 32'h3F800000; op2 = 32'h40400000; end
            if (cyc == 6) ready = 1'b0;
            if (done) begin ndone++; r = res; end
        end
        tests++; if (ndone != 1) begin fails++; $display("FAIL ignore_ready_count: got %0d want 1", ndone); end
        tests++; if (r !== 32'h40400000) begin fails++; $display("FAIL ignore_ready_res: got %h want 40400000", r); end
    endtask

    task automatic test_back_to_back();
        int d0 = -1, d1 = -1; logic [31:0] r0 = 32'd0, r1 = 32'd0, mid = 32'd0;
        @(negedge clk);
        op1 = 32'h40C00000; op2 = 32'h40000000; ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op1 = 32'h3F800000; op2 = 32'h40400000;
        for (int cyc = 1; cyc <= 100 && d1 < 0; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 45) mid = res;
            if (done) begin
                if (d0 < 0) begin d0 = cyc; r0 = res; end
                else begin d1 = cyc; r1 = res; ready = 1'b0; end
            end
        end
        ready = 1'b0;
        tests++; if (r0 !== 32'h40400000) begin fails++; $display("FAIL b2b_first: got %h want 40400000", r0); end
        tests++; if (r1 !== 32'h3EAAAAAB) begin fails++; $display("FAIL b2b_second: got %h want 3EAAAAAB", r1); end
        tests++; if (d1 - d0 != 32) begin fails++; $display("FAIL b2b_gap: got %0d want 32", d1 - d0); end
        tests++; if (mid !== 32'h40400000) begin fails++; $display("FAIL b2b_res_held: got %h want 40400000", mid); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int ndone = 0; logic [31:0] r; int lat; logic bok;
        @(negedge clk);
        op1 = 32'h40C00000; op2 = 32'h40000000; ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++; if (res !== 32'd0) begin fails++; $display("FAIL midreset_res: got %h want 00000000", res); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL midreset_done: got %b want 0", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        tests++; if (ndone != 0) begin fails++; $display("FAIL midreset_no_done: got %0d want 0", ndone); end
        run_op(32'h40400000, 32'h3F800000, r, lat, bok);
        tests++; if (r !== 32'h40400000) begin fails++; $display("FAIL after_reset_op: got %h want 40400000", r); end
        tests++; if (lat != 31) begin fails++; $display("FAIL after_reset_latency: got %0d want 31", lat); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_round();
        test_specials();
        test_range();
        test_ignore_ready();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
